// File: rtl/error_pkg.sv
// Shared definitions for the error collector: clear-FSM state encodings
// and default sizing for sources, counters and timestamp.
package error_pkg;

  localparam int DEF_N_ERR = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_TS_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/err_counter.sv
// Saturating per-source occurrence counter. A clear coinciding with an
// increment leaves the counter at 1 (set wins over clear).
module err_counter
  import error_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // count events, hold at all-ones, restart from 0 or 1 on clear
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/error_collector.sv
// Error collector: masks raw error inputs, keeps sticky flags and
// saturating counters per source, captures the first error with a
// timestamp, and runs a one-shot clear handshake.
module error_collector
  import error_pkg::*;
#(
  parameter  int N_ERR = DEF_N_ERR,
  parameter  int CNT_W = DEF_CNT_W,
  parameter  int TS_W  = DEF_TS_W,
  localparam int IDX_W = $clog2(N_ERR)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [N_ERR-1:0] i_err_in,
  input  logic [N_ERR-1:0] i_err_mask,
  input  logic             i_clr_req,
  output logic             o_clr_ack,
  output logic [N_ERR-1:0] o_sticky,
  output logic             o_any_err,
  output logic             o_first_valid,
  output logic [IDX_W-1:0] o_first_idx,
  output logic [TS_W-1:0]  o_first_time,
  input  logic [IDX_W-1:0] i_rd_sel,
  output logic [CNT_W-1:0] o_rd_count
);

  clr_state_t       r_state;
  logic             r_clr_ack;
  logic [TS_W-1:0]  r_ts;
  logic [N_ERR-1:0] r_sticky;
  logic             r_first_valid;
  logic [IDX_W-1:0] r_first_idx;
  logic [TS_W-1:0]  r_first_time;

  logic [N_ERR-1:0] w_eff;
  logic             w_any_eff;
  logic             w_clear;
  logic [IDX_W-1:0] w_low_idx;
  logic [CNT_W-1:0] w_cnt [N_ERR];
  logic [CNT_W-1:0] w_rd_count;

  assign w_eff     = i_err_in & ~i_err_mask;
  assign w_any_eff = |w_eff;
  // The clear is applied on the edge that leaves CLEAR.
  assign w_clear   = (r_state == ST_CLEAR);

  // free-running timestamp, untouched by the clear handshake
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // clear handshake: one ack cycle per request, held requests wait in HOLD
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_clr_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ack <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state   <= ST_HOLD;
          r_clr_ack <= 1'b0;
        end
        ST_HOLD: begin
          if (!i_clr_req) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clr_ack <= 1'b0;
        end
      endcase
    end
  end

  // sticky flags; a new error in the clear cycle survives the clear
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sticky <= '0;
    end else if (w_clear) begin
      r_sticky <= w_eff;
    end else begin
      r_sticky <= r_sticky | w_eff;
    end
  end

  // lowest-index active source wins the first-error capture
  always_comb begin
    w_low_idx = '0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (w_eff[i]) begin
        w_low_idx = IDX_W'(i);
      end
    end
  end

  // first-error capture; the clear cycle re-arms it and may capture anew
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_first_time  <= '0;
    end else if ((w_clear || !r_first_valid) && w_any_eff) begin
      r_first_valid <= 1'b1;
      r_first_idx   <= w_low_idx;
      r_first_time  <= r_ts;
    end else if (w_clear) begin
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_first_time  <= '0;
    end
  end

  for (genvar gi = 0; gi < N_ERR; gi++) begin : g_cnt
    err_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clr   (w_clear),
      .i_inc   (w_eff[gi]),
      .o_count (w_cnt[gi])
    );
  end

  // counter readback; selects with no matching source read as zero
  always_comb begin
    w_rd_count = '0;
    for (int i = 0; i < N_ERR; i++) begin
      if (int'(i_rd_sel) == i) begin
        w_rd_count = w_cnt[i];
      end
    end
  end

  assign o_clr_ack     = r_clr_ack;
  assign o_sticky      = r_sticky;
  assign o_any_err     = |r_sticky;
  assign o_first_valid = r_first_valid;
  assign o_first_idx   = r_first_idx;
  assign o_first_time  = r_first_time;
  assign o_rd_count    = w_rd_count;

endmodule

// File: tb/tb_error_collector.sv
// Bench for error_collector: directed stimulus, a behavioural model
// checked every cycle, and literal expectations for key scenarios.
module tb_error_collector;

  localparam int N  = 8;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  err_in = '0;
  logic [N-1:0]  err_mask = '0;
  logic          clr_req = 1'b0;
  logic [IW-1:0] rd_sel = '0;
  logic          o_clr_ack;
  logic [N-1:0]  o_sticky;
  logic          o_any_err;
  logic          o_first_valid;
  logic [IW-1:0] o_first_idx;
  logic [TW-1:0] o_first_time;
  logic [CW-1:0] o_rd_count;

  int total = 0;
  int bad   = 0;

  error_collector #(
    .N_ERR (N),
    .CNT_W (CW),
    .TS_W  (TW)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_err_in      (err_in),
    .i_err_mask    (err_mask),
    .i_clr_req     (clr_req),
    .o_clr_ack     (o_clr_ack),
    .o_sticky      (o_sticky),
    .o_any_err     (o_any_err),
    .o_first_valid (o_first_valid),
    .o_first_idx   (o_first_idx),
    .o_first_time  (o_first_time),
    .i_rd_sel      (rd_sel),
    .o_rd_count    (o_rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_sticky;
  int         m_cnt [N];
  bit         m_fv;
  int         m_fidx;
  int         m_ftime;
  int         m_ts;
  bit         m_ack;    // clear acknowledged during the current cycle
  bit         m_wait;   // request serviced, waiting for it to drop
  bit         m_on = 1'b0;
  bit [N-1:0] m_eff;
  bit         m_clearing;
  bit         m_nack;
  bit         m_found;

  always @(posedge clk) begin
    if (rst) begin
      m_sticky = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_fv = 0; m_fidx = 0; m_ftime = 0; m_ts = 0;
      m_ack = 0; m_wait = 0;
      m_on = 1'b1;
    end else begin
      m_eff      = err_in & ~err_mask;
      m_clearing = m_ack;
      m_nack     = !m_ack && !m_wait && clr_req;
      if (m_ack) m_wait = 1;
      else if (m_wait && !clr_req) m_wait = 0;
      m_ack = m_nack;
      for (int i = 0; i < N; i++) begin
        if (m_clearing) m_cnt[i] = m_eff[i] ? 1 : 0;
        else if (m_eff[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i] = m_cnt[i] + 1;
      end
      m_sticky = m_clearing ? m_eff : (m_sticky | m_eff);
      if (m_clearing) begin
        m_fv = 0; m_fidx = 0; m_ftime = 0;
      end
      if (!m_fv && m_eff != 0) begin
        m_found = 0;
        for (int i = 0; i < N; i++) begin
          if (m_eff[i] && !m_found) begin
            m_fidx  = i;
            m_found = 1;
          end
        end
        m_fv    = 1;
        m_ftime = m_ts;
      end
      m_ts = (m_ts + 1) % (1 << TW);
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_on) begin
      chk("clr_ack", o_clr_ack, m_ack);
      chk("sticky", o_sticky, m_sticky);
      chk("any_err", o_any_err, (m_sticky != 0) ? 1 : 0);
      chk("first_valid", o_first_valid, m_fv);
      chk("first_idx", o_first_idx, m_fidx);
      chk("first_time", o_first_time, m_ftime);
      chk("rd_count", o_rd_count, (int'(rd_sel) < N) ? m_cnt[rd_sel] : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  int acks;

  initial begin
    // single error at timestamp 5
    do_reset();
    rd_sel = 3'd2;
    step(5);
    err_in = 8'h04;
    step(1);
    err_in = '0;
    settle();
    $display("txn err 0x04 at ts 5: sticky=%h idx=%0d time=%0d", o_sticky, o_first_idx, o_first_time);
    chk("t1_sticky", o_sticky, 8'h04);
    chk("t1_any", o_any_err, 1);
    chk("t1_idx", o_first_idx, 2);
    chk("t1_time", o_first_time, 5);
    chk("t1_cnt2", o_rd_count, 1);

    // masked source has no effect
    do_reset();
    err_mask = 8'h01; err_in = 8'h01; rd_sel = 3'd0;
    step(10);
    err_in = '0; err_mask = '0;
    settle();
    $display("txn masked src0 x10: sticky=%h cnt0=%0d fv=%0d", o_sticky, o_rd_count, o_first_valid);
    chk("t2_sticky", o_sticky, 0);
    chk("t2_cnt0", o_rd_count, 0);
    chk("t2_fv", o_first_valid, 0);

    // simultaneous errors pick the lowest index; later errors do not recapture
    do_reset();
    err_in = 8'h0A;
    step(1);
    err_in = 8'h00;
    settle();
    rd_sel = 3'd1; #1;
    chk("t3_cnt1", o_rd_count, 1);
    rd_sel = 3'd3; #1;
    chk("t3_cnt3", o_rd_count, 1);
    chk("t3_idx", o_first_idx, 1);
    err_in = 8'h01;
    step(1);
    err_in = 8'h00;
    settle();
    $display("txn err 0x0A then 0x01: idx=%0d sticky=%h", o_first_idx, o_sticky);
    chk("t3_idx_keep", o_first_idx, 1);
    chk("t3_sticky", o_sticky, 8'h0B);

    // saturation of counter 7
    rd_sel = 3'd7;
    err_in = 8'h80;
    step(300);
    err_in = '0;
    settle();
    $display("txn err7 x300: cnt7=%0d", o_rd_count);
    chk("t4_sat", o_rd_count, 255);

    // held clear request yields a single ack and zeroes all state
    acks = 0;
    clr_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      settle();
      acks += int'(o_clr_ack);
    end
    clr_req = 1'b0;
    $display("txn clr held 5: acks=%0d sticky=%h fv=%0d", acks, o_sticky, o_first_valid);
    chk("t5_acks", acks, 1);
    chk("t5_sticky", o_sticky, 0);
    chk("t5_fv", o_first_valid, 0);
    chk("t5_cnt7", o_rd_count, 0);
    step(1);
    // error in the clear cycle wins
    clr_req = 1'b1;
    step(1);
    err_in = 8'h10;
    step(1);
    err_in = '0; clr_req = 1'b0;
    settle();
    rd_sel = 3'd4; #1;
    $display("txn err 0x10 in clear: sticky=%h cnt4=%0d idx=%0d", o_sticky, o_rd_count, o_first_idx);
    chk("t5_set_sticky", o_sticky, 8'h10);
    chk("t5_set_cnt4", o_rd_count, 1);
    chk("t5_set_idx", o_first_idx, 4);
    chk("t5_set_fv", o_first_valid, 1);
    step(2);

    // reset while in HOLD, request still high afterwards
    clr_req = 1'b1;
    step(2);
    err_in = 8'h20;
    step(1);
    err_in = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    settle();
    $display("txn reset in hold: ack=%0d sticky=%h fv=%0d", o_clr_ack, o_sticky, o_first_valid);
    chk("t6_ack", o_clr_ack, 0);
    chk("t6_sticky", o_sticky, 0);
    chk("t6_any", o_any_err, 0);
    chk("t6_fv", o_first_valid, 0);
    chk("t6_cnt", o_rd_count, 0);
    step(1);
    settle();
    $display("txn clear after reset: ack=%0d", o_clr_ack);
    chk("t6_new_ack", o_clr_ack, 1);
    clr_req = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
